regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised successor to the core register file. It keeps synchronous write and asynchronous read, and adds:
- configurable data width, depth and read-port count;
- optional hard-wired zero register;
- optional write-to-read bypass;
- a post-reset clear sequencer;
- a per-entry pending-write scoreboard for the hazard logic in the decode stage.

Parameters:
DATA_W, 32, data width of each entry.
ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W.
NUM_RD, 2, number of asynchronous read ports (1..4).
ZERO_REG, 1, 1 = entry 0 always reads 0, is never written and is never marked busy.
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
o_ready  out  1  1 = clear sequence finished, file usable.
i_wen  in  1  write enable.
i_waddr  in  ADDR_W  write address.
i_wdata  in  DATA_W  write data.
i_alloc  in  1  mark an entry as awaiting a write (instruction issued).
i_alloc_addr  in  ADDR_W  entry to mark.
i_raddr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
o_rdata  out  NUM_RD*DATA_W  read data, packed the same way.
o_rbusy  out  NUM_RD  per-port 1 = addressed entry has a pending write not yet available.

Behaviour:
- FSM has two states, CLEAR and READY.
- rst=1 at an edge: state goes to CLEAR, clear counter goes to 0, all scoreboard bits go to 0, o_ready=0. Reset mid-operation restarts the clear from entry 0.
- CLEAR:
  - each cycle writes 0 to entry[counter] and increments the counter;
  - after the cycle that clears entry DEPTH-1, state goes to READY (DEPTH cycles total after rst deasserts);
  - o_ready=0 throughout;
  - i_wen and i_alloc are ignored;
  - o_rdata is all 0 and o_rbusy is all 0.
- READY: o_ready=1 and stays there until the next rst.
- Write: in READY with i_wen=1, entry[i_waddr] <= i_wdata at the edge. If ZERO_REG=1 and i_waddr=0, nothing is written.
- Read is combinational. Port k returns entry[raddr_k], except:
  - returns 0 when ZERO_REG=1 and raddr_k=0;
  - returns i_wdata when BYPASS=1, i_wen=1, READY, and i_waddr==raddr_k (nonzero if ZERO_REG=1).
- Scoreboard, at each edge in READY:
  - i_wen with address A clears busy[A];
  - i_alloc with address B sets busy[B];
  - if both fire with A==B, alloc wins and busy stays set (a new producer replaces the completing one);
  - entry 0 is never set when ZERO_REG=1.
- o_rbusy[k] = busy[raddr_k], forced to 0 when:
  - BYPASS=1 and the same-cycle write matches raddr_k;
  - ZERO_REG=1 and raddr_k=0.
- Multiple read ports may address the same entry; each resolves independently.
- No read/write ordering hazard without BYPASS: a same-cycle read returns the old value.

Decomposition:
- Shared package rf_pkg holds:
  - typedef rf_state_t {RF_CLEAR, RF_READY};
  - constants RF_DATA_W_DEF=32 and RF_ADDR_W_DEF=5.
- One sub-module, regfile_rd_port, resolves a single read port: zero check, bypass mux and busy masking. It is instantiated NUM_RD times via generate.
- The storage array, the FSM and the scoreboard stay in the top level.

Test Plan:
1. Hold rst for 1 cycle, then release. Required: o_ready=0 for exactly 32 cycles then 1; every read of entries 0..31 returns 0x00000000 and o_rbusy=0.
2. Write entry 5 = 0xDEADBEEF, then read port0=5 and port1=5 the next cycle. Required: both ports return 0xDEADBEEF.
3. In the same cycle write entry 7 = 0x12345678 and read port0=7. Required: 0x12345678 with BYPASS=1, the old value with BYPASS=0.
4. Write entry 0 = 0xFFFFFFFF and alloc entry 0, then read 0. Required: data 0 and o_rbusy=0.
5. Alloc entry 3; next cycle read 3 (expect busy=1); then write entry 3 = 0xA5A5A5A5 with alloc entry 3 in the same cycle; then write entry 3 = 0x1 with no alloc. Required: busy=0 during each write cycle (bypassed); busy=1 after the combined write+alloc; busy=0 after the final write.
6. Assert rst while in READY with entry 9 = 0x55 and busy[9]=1. Required: o_ready drops, entry 9 reads 0 after the clear, busy[9]=0, and writes issued during CLEAR have no effect.

Source files
------------

// File: rtl/rf_pkg.sv
// ============================================================================
// Module : rf_pkg
// Shared state encoding and default sizes for the multi-port register file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rf_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_ADDR_W_DEF = 5;

endpackage

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ============================================================================
// Module : regfile_rd_port
// Resolves one asynchronous read port: zero register, write bypass, busy mask.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_rd_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              i_ready,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_busy,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rbusy
);

    logic w_is_zero;
    logic w_bypass;

    assign w_is_zero = (ZERO_REG != 0) && (i_raddr == '0);
    assign w_bypass  = (BYPASS != 0) && i_wen && (i_waddr == i_raddr);

    // Zero register takes precedence so a write to entry 0 is never forwarded.
    always_comb begin
        o_rdata = '0;
        o_rbusy = 1'b0;
        if (i_ready && !w_is_zero) begin
            if (w_bypass) begin
                o_rdata = i_wdata;
            end else begin
                o_rdata = i_mem_data;
                o_rbusy = i_busy;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module : regfile_mp
// Parametrised register file with clear sequencer and pending-write scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     o_ready,
    input  logic                     i_wen,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_alloc,
    input  logic [ADDR_W-1:0]        i_alloc_addr,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD*DATA_W-1:0] o_rdata,
    output logic [NUM_RD-1:0]        o_rbusy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic w_ready;
    logic w_wen_eff;
    logic w_alloc_eff;

    assign w_ready     = (state_q == RF_READY);
    assign o_ready     = w_ready;
    assign w_wen_eff   = w_ready && i_wen && !((ZERO_REG != 0) && (i_waddr == '0));
    assign w_alloc_eff = w_ready && i_alloc && !((ZERO_REG != 0) && (i_alloc_addr == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            RF_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    state_d = RF_READY;
                end
            end
            default: begin
                // Alloc is applied last so a new producer wins over a completing one.
                if (w_wen_eff) begin
                    busy_d[i_waddr] = 1'b0;
                end
                if (w_alloc_eff) begin
                    busy_d[i_alloc_addr] = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset; the clear sequencer zeroes it after rst drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == RF_CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else if (w_wen_eff) begin
                mem_q[i_waddr] <= i_wdata;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
            logic [ADDR_W-1:0] w_addr;
            assign w_addr = i_raddr[k*ADDR_W +: ADDR_W];

            regfile_rd_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rd_port (
                .i_ready    (w_ready),
                .i_raddr    (w_addr),
                .i_mem_data (mem_q[w_addr]),
                .i_busy     (busy_q[w_addr]),
                .i_wen      (i_wen),
                .i_waddr    (i_waddr),
                .i_wdata    (i_wdata),
                .o_rdata    (o_rdata[k*DATA_W +: DATA_W]),
                .o_rbusy    (o_rbusy[k])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module : tb_regfile_mp
// Scoreboard bench for regfile_mp against an array-based reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
    localparam int ZR    = 1;
    localparam int BP    = 1;

    logic           clk;
    logic           rst;
    logic           o_ready;
    logic           i_wen;
    logic [AW-1:0]  i_waddr;
    logic [DW-1:0]  i_wdata;
    logic           i_alloc;
    logic [AW-1:0]  i_alloc_addr;
    logic [NR*AW-1:0] i_raddr;
    logic [NR*DW-1:0] o_rdata;
    logic [NR-1:0]  o_rbusy;

    regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(ZR), .BYPASS(BP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .o_ready      (o_ready),
        .i_wen        (i_wen),
        .i_waddr      (i_waddr),
        .i_wdata      (i_wdata),
        .i_alloc      (i_alloc),
        .i_alloc_addr (i_alloc_addr),
        .i_raddr      (i_raddr),
        .o_rdata      (o_rdata),
        .o_rbusy      (o_rbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             ready;
        logic [NR*DW-1:0] rdata;
        logic [NR-1:0]    rbusy;
        string            tag;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: plain arrays plus a count of clear cycles still to run.
    logic [DW-1:0] m_mem  [DEPTH];
    logic          m_busy [DEPTH];
    int            m_clear_left = DEPTH;
    bit            m_known = 0;

    task automatic chk(input string name, input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s (%s): got %h expected %h", name, tag, act, exp);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("ready", e.tag, 64'(o_ready), 64'(e.ready));
                for (int k = 0; k < NR; k++) begin
                    chk($sformatf("rdata%0d", k), e.tag, 64'(o_rdata[k*DW +: DW]),
                        64'(e.rdata[k*DW +: DW]));
                    chk($sformatf("rbusy%0d", k), e.tag, 64'(o_rbusy[k]), 64'(e.rbusy[k]));
                end
            end
        end
    end

    task automatic cycle(input string tag, input logic r, input logic wen,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic al, input logic [AW-1:0] aa,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        exp_t e;
        logic [AW-1:0] ra [NR];
        logic rdy;
        ra[0] = ra0;
        ra[1] = ra1;
        rst = r; i_wen = wen; i_waddr = wa; i_wdata = wd;
        i_alloc = al; i_alloc_addr = aa; i_raddr = {ra1, ra0};
        if (m_known) begin
            rdy = (m_clear_left == 0);
            e.ready = rdy;
            e.tag   = tag;
            e.rdata = '0;
            e.rbusy = '0;
            for (int k = 0; k < NR; k++) begin
                if (!rdy || (ZR != 0 && ra[k] == 0)) begin
                    e.rdata[k*DW +: DW] = '0;
                    e.rbusy[k] = 1'b0;
                end else if (BP != 0 && wen && wa == ra[k]) begin
                    e.rdata[k*DW +: DW] = wd;
                    e.rbusy[k] = 1'b0;
                end else begin
                    e.rdata[k*DW +: DW] = m_mem[ra[k]];
                    e.rbusy[k] = m_busy[ra[k]];
                end
            end
            sbq.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            m_known = 1;
            m_clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else if (m_known) begin
            if (m_clear_left > 0) begin
                m_clear_left--;
            end else begin
                if (wen && !(ZR != 0 && wa == 0)) begin
                    m_mem[wa] = wd;
                    m_busy[wa] = 1'b0;
                end
                if (al && !(ZR != 0 && aa == 0)) m_busy[aa] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input string tag, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        cycle(tag, 1'b0, 1'b0, '0, '0, 1'b0, '0, ra0, ra1);
    endtask

    initial begin
        int wait_cnt;
        rst = 1'b1; i_wen = 0; i_waddr = 0; i_wdata = 0;
        i_alloc = 0; i_alloc_addr = 0; i_raddr = 0;

        // Reset and clear sequence, reading every entry while it runs and afterwards.
        cycle("reset", 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        for (int i = 0; i < DEPTH; i++) idle("clear", AW'(i), AW'(DEPTH - 1 - i));
        for (int i = 0; i < DEPTH; i++) idle("cleared", AW'(i), AW'(i ^ 1));

        // Write then dual-port read of the same entry.
        cycle("wr5", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd1, 5'd2);
        idle("rd5", 5'd5, 5'd5);

        // Same-cycle write and read: bypass.
        cycle("byp7", 1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, '0, 5'd7, 5'd5);
        idle("rd7", 5'd7, 5'd7);

        // Zero register: write and alloc are dropped.
        cycle("zero_wr", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        idle("zero_rd", 5'd0, 5'd0);

        // Scoreboard: alloc, combined write+alloc, final write.
        cycle("alloc3", 1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd4);
        idle("busy3", 5'd3, 5'd3);
        cycle("wa3", 1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 5'd3, 5'd3);
        idle("still_busy3", 5'd3, 5'd3);
        cycle("w3", 1'b0, 1'b1, 5'd3, 32'h00000001, 1'b0, '0, 5'd3, 5'd3);
        idle("free3", 5'd3, 5'd3);

        // Reset from READY with live state; writes during CLEAR must not land.
        cycle("w9", 1'b0, 1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd9);
        idle("pre_rst9", 5'd9, 5'd9);
        cycle("rst2", 1'b1, 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
        for (int i = 0; i < DEPTH; i++)
            cycle("clr_wr", 1'b0, 1'b1, 5'd9, 32'hBAD0_0000 | 32'(i), 1'b1, 5'd9, 5'd9, 5'd3);
        idle("post9", 5'd9, 5'd3);

        // Randomised traffic on a narrow address range to provoke hazards.
        for (int n = 0; n < 800; n++) begin
            cycle("rand", ($urandom_range(0, 199) == 0),
                  1'($urandom), AW'($urandom_range(0, 7)), $urandom,
                  1'($urandom), AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sbq.size() > 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
